// File: rtl/cls_recovery_seq.sv
`default_nettype none
// ============================================================================
// Module   : cls_recovery_seq
// Purpose  : Recovery sequencer for a triple-core lockstep cluster. On an
//            accepted compare fault the cluster is held in reset, given a
//            settle interval, then released. Too many faults inside one
//            observation window park the cluster in LOCKOUT until cleared.
// Ports    : clk_i          - single clock
//            rst_ni         - asynchronous active-low reset
//            fault_i        - lockstep mismatch flag (level)
//            fault_src_i    - per-core disagreement vector, valid with fault_i
//            clear_i        - request to leave LOCKOUT
//            rst_cls_no     - active-low reset to the cores and compare unit
//            recovering_o   - high in RESET or SETTLE
//            lockout_o      - high in LOCKOUT
//            fault_count_o  - accepted faults, saturating at 255
//            last_src_o     - fault_src_i captured at the last accepted fault
// Revision : 1.0 - initial release
// ============================================================================
module cls_recovery_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int WINDOW_CYCLES = 1024,
    parameter int MAX_FAULTS    = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fault_i,
    input  logic [2:0] fault_src_i,
    input  logic       clear_i,
    output logic       rst_cls_no,
    output logic       recovering_o,
    output logic       lockout_o,
    output logic [7:0] fault_count_o,
    output logic [2:0] last_src_o
);

    localparam int C_CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_WIN_W   = $clog2(WINDOW_CYCLES);

    localparam logic [C_CNT_W-1:0] C_RST_LOAD    = C_CNT_W'(RST_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_SETTLE_LOAD = C_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [C_WIN_W-1:0] C_WIN_LAST    = C_WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [3:0]         C_MAX_FAULTS  = 4'(MAX_FAULTS);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RUN     = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_fault_q;
    logic [3:0]           r_win_cnt;
    logic                 r_win_active;
    logic [C_WIN_W-1:0]   r_win_timer;

    logic                 w_accept;
    logic                 w_expire;
    logic [3:0]           w_win_base;
    logic [3:0]           w_win_inc;

    // Only a rising edge of fault_i while in RUN is a new fault; a level that
    // was already high when RUN was entered never produces an edge.
    assign w_accept = (r_state == ST_RUN) && fault_i && !r_fault_q;

    // The window timer is frozen in LOCKOUT, so it cannot expire there.
    assign w_expire = r_win_active && (r_win_timer == C_WIN_LAST) && (r_state != ST_LOCKOUT);

    // Expiry is applied before a coincident fault is counted.
    assign w_win_base = w_expire ? 4'd0 : r_win_cnt;
    assign w_win_inc  = w_win_base + 4'd1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RESET:   if (r_cnt == '0) w_state_next = ST_SETTLE;
            ST_SETTLE:  if (r_cnt == '0) w_state_next = ST_RUN;
            ST_RUN:     if (w_accept)
                            w_state_next = (w_win_inc == C_MAX_FAULTS) ? ST_LOCKOUT : ST_RESET;
            ST_LOCKOUT: if (clear_i) w_state_next = ST_RESET;
            default:    w_state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_RESET;
            r_cnt         <= C_RST_LOAD;
            r_fault_q     <= 1'b0;
            r_win_cnt     <= 4'd0;
            r_win_active  <= 1'b0;
            r_win_timer   <= '0;
            rst_cls_no    <= 1'b0;
            recovering_o  <= 1'b1;
            lockout_o     <= 1'b0;
            fault_count_o <= 8'd0;
            last_src_o    <= 3'd0;
        end else begin
            r_state   <= w_state_next;
            r_fault_q <= fault_i;

            // Outputs are decoded from the next state so they line up with it.
            rst_cls_no   <= (w_state_next == ST_SETTLE) || (w_state_next == ST_RUN);
            recovering_o <= (w_state_next == ST_RESET)  || (w_state_next == ST_SETTLE);
            lockout_o    <= (w_state_next == ST_LOCKOUT);

            // Phase counter reloads on every state change, otherwise counts down.
            if (w_state_next != r_state) begin
                case (w_state_next)
                    ST_RESET:  r_cnt <= C_RST_LOAD;
                    ST_SETTLE: r_cnt <= C_SETTLE_LOAD;
                    default:   r_cnt <= '0;
                endcase
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - C_CNT_W'(1);
            end

            // Fault-rate window.
            if (r_state == ST_LOCKOUT) begin
                if (clear_i) begin
                    r_win_cnt    <= 4'd0;
                    r_win_active <= 1'b0;
                    r_win_timer  <= '0;
                end
            end else if (w_accept) begin
                r_win_cnt <= w_win_inc;
                if (w_win_base == 4'd0) begin
                    r_win_active <= 1'b1;
                    r_win_timer  <= '0;
                end else begin
                    r_win_timer <= r_win_timer + C_WIN_W'(1);
                end
            end else if (w_expire) begin
                r_win_cnt    <= 4'd0;
                r_win_active <= 1'b0;
                r_win_timer  <= '0;
            end else if (r_win_active) begin
                r_win_timer <= r_win_timer + C_WIN_W'(1);
            end

            if (w_accept) begin
                last_src_o <= fault_src_i;
                if (fault_count_o != 8'hFF)
                    fault_count_o <= fault_count_o + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cls_recovery_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cls_recovery_seq
// Purpose  : Self-checking bench for cls_recovery_seq. Stimulus pushes the
//            expected outcome of each recovery (RUN re-entry or LOCKOUT entry)
//            into a queue; a monitor measures each recovery and compares.
//            A second instance with a short window checks counter saturation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cls_recovery_seq;

    typedef struct {
        bit is_lock;
        int cnt;
        int src;
    } exp_t;

    localparam int C_RST    = 16;
    localparam int C_SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       fault_i;
    logic [2:0] fault_src_i;
    logic       clear_i;
    logic       rst_cls_no;
    logic       recovering_o;
    logic       lockout_o;
    logic [7:0] fault_count_o;
    logic [2:0] last_src_o;

    logic       s_fault;
    logic [2:0] s_src;
    logic       s_clear;
    logic       s_rst_cls_n;
    logic       s_recovering;
    logic       s_lockout;
    logic [7:0] s_count;
    logic [2:0] s_last_src;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cls_recovery_seq dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fault_i      (fault_i),
        .fault_src_i  (fault_src_i),
        .clear_i      (clear_i),
        .rst_cls_no   (rst_cls_no),
        .recovering_o (recovering_o),
        .lockout_o    (lockout_o),
        .fault_count_o(fault_count_o),
        .last_src_o   (last_src_o)
    );

    cls_recovery_seq #(
        .RST_CYCLES   (2),
        .SETTLE_CYCLES(1),
        .WINDOW_CYCLES(4),
        .MAX_FAULTS   (15)
    ) dut_sat (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fault_i      (s_fault),
        .fault_src_i  (s_src),
        .clear_i      (s_clear),
        .rst_cls_no   (s_rst_cls_n),
        .recovering_o (s_recovering),
        .lockout_o    (s_lockout),
        .fault_count_o(s_count),
        .last_src_o   (s_last_src)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit lk, input int c, input int s);
        exp_t e;
        e.is_lock = lk;
        e.cnt     = c;
        e.src     = s;
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures reset-low and settle lengths of each recovery and
    // compares at RUN re-entry or LOCKOUT entry.
    // ------------------------------------------------------------------
    int   rst_len    = 0;
    int   settle_len = 0;
    bit   prev_rec   = 1'b1;
    bit   prev_lock  = 1'b0;
    exp_t m_e;

    always @(negedge clk) begin
        if (!rst_ni) begin
            rst_len    = 0;
            settle_len = 0;
            prev_rec   = 1'b1;
            prev_lock  = 1'b0;
        end else begin
            if (!rst_cls_no && !lockout_o) rst_len++;
            if (recovering_o && rst_cls_no) settle_len++;
            if ((prev_rec && !recovering_o) || (!prev_lock && lockout_o)) begin
                if (exp_q.size() == 0) begin
                    check("mon.unexpected_event", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("mon.kind_is_lock", int'(lockout_o), int'(m_e.is_lock));
                    check("mon.fault_count", int'(fault_count_o), m_e.cnt);
                    check("mon.last_src", int'(last_src_o), m_e.src);
                    if (lockout_o) begin
                        check("mon.lock_rst_cls_no", int'(rst_cls_no), 0);
                    end else begin
                        check("mon.rst_low_len", rst_len, C_RST);
                        check("mon.settle_len", settle_len, C_SETTLE);
                    end
                end
                rst_len    = 0;
                settle_len = 0;
            end
            prev_rec  = recovering_o;
            prev_lock = lockout_o;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_fault(input logic [2:0] src, input int len);
        @(negedge clk);
        fault_i     = 1'b1;
        fault_src_i = src;
        repeat (len) @(negedge clk);
        fault_i = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(rst_cls_no && !recovering_o && !lockout_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("timeout.wait_run", 0, 1);
    endtask

    task automatic wait_settle();
        int n = 0;
        while (!(rst_cls_no && recovering_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("timeout.wait_settle", 0, 1);
    endtask

    task automatic wait_lockout();
        int n = 0;
        while (!lockout_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("timeout.wait_lockout", 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rst_cls_no"},   int'(rst_cls_no),    0);
        check({tag, ".recovering_o"}, int'(recovering_o),  1);
        check({tag, ".lockout_o"},    int'(lockout_o),     0);
        check({tag, ".fault_count"},  int'(fault_count_o), 0);
        check({tag, ".last_src"},     int'(last_src_o),    0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int t_a;
    int n_s;

    initial begin
        rst_ni      = 1'b0;
        fault_i     = 1'b0;
        fault_src_i = 3'd0;
        clear_i     = 1'b0;
        s_fault     = 1'b0;
        s_src       = 3'd0;
        s_clear     = 1'b0;

        repeat (3) @(negedge clk);
        #1 check_reset_values("por");

        // Power-on release: 16 low, 4 settle, RUN with zero count.
        push_exp(1'b0, 0, 0);
        @(posedge clk); #2 rst_ni = 1'b1;
        wait_run();

        // clear_i outside LOCKOUT has no effect.
        pulse_clear();
        repeat (5) @(negedge clk);

        // Single fault pulse.
        push_exp(1'b0, 1, 3'b010);
        pulse_fault(3'b010, 1);
        wait_run();

        // Fault held high 50 cycles counts once.
        push_exp(1'b0, 2, 3'b100);
        pulse_fault(3'b100, 50);
        repeat (10) @(negedge clk);
        wait_run();

        // Third fault in the window forces LOCKOUT, held indefinitely.
        push_exp(1'b1, 3, 3'b001);
        pulse_fault(3'b001, 1);
        wait_lockout();
        repeat (100) @(negedge clk);
        check("lock_hold.rst_cls_no", int'(rst_cls_no), 0);
        check("lock_hold.lockout_o",  int'(lockout_o),  1);

        // Clear gives a full recovery, count retained.
        push_exp(1'b0, 3, 3'b001);
        pulse_clear();
        wait_run();

        // Window expiry: A, B, then C 1100 cycles after A -> no lockout.
        t_a = cyc;
        push_exp(1'b0, 4, 3'b011);
        pulse_fault(3'b011, 1);
        wait_run();
        push_exp(1'b0, 5, 3'b101);
        pulse_fault(3'b101, 1);
        wait_run();
        while (cyc < t_a + 1100) @(negedge clk);
        push_exp(1'b0, 6, 3'b110);
        pulse_fault(3'b110, 1);
        wait_run();
        // win_cnt is 1 after C: two more faults reach lockout.
        push_exp(1'b0, 7, 3'b010);
        pulse_fault(3'b010, 1);
        wait_run();
        push_exp(1'b1, 8, 3'b100);
        pulse_fault(3'b100, 1);
        wait_lockout();
        push_exp(1'b0, 8, 3'b100);
        pulse_clear();
        wait_run();

        // Fault raised and dropped inside SETTLE is ignored.
        push_exp(1'b0, 9, 3'b001);
        pulse_fault(3'b001, 1);
        wait_settle();
        pulse_fault(3'b111, 2);
        wait_run();

        // Fault raised in SETTLE and still high entering RUN is ignored.
        push_exp(1'b0, 10, 3'b100);
        pulse_fault(3'b100, 1);
        wait_settle();
        pulse_fault(3'b111, 10);
        repeat (5) @(negedge clk);
        wait_run();
        check("settle_hold.fault_count", int'(fault_count_o), 10);
        check("settle_hold.last_src",    int'(last_src_o),    3'b100);

        // Third fault in window -> LOCKOUT, then async reset mid-LOCKOUT.
        push_exp(1'b1, 11, 3'b011);
        pulse_fault(3'b011, 1);
        wait_lockout();
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst_ni = 1'b0;
        #1 check_reset_values("rst_in_lockout");
        push_exp(1'b0, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_ni = 1'b1;
        wait_run();

        // Async reset mid-RESET aborts the recovery.
        pulse_fault(3'b110, 1);
        repeat (5) @(negedge clk);
        check("mid_reset.fault_count", int'(fault_count_o), 1);
        check("mid_reset.rst_cls_no",  int'(rst_cls_no),    0);
        @(posedge clk); #2 rst_ni = 1'b0;
        #1 check_reset_values("rst_in_reset");
        push_exp(1'b0, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_ni = 1'b1;
        wait_run();

        repeat (10) @(negedge clk);
        check("end.queue_empty", exp_q.size(), 0);

        // Saturation on the short-window instance.
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            s_fault = 1'b1;
            s_src   = 3'(i);
            @(negedge clk);
            s_fault = 1'b0;
            n_s = 0;
            while (!(s_rst_cls_n && !s_recovering && !s_lockout) && n_s < 100) begin
                @(negedge clk);
                n_s++;
            end
            if (n_s >= 100) check("timeout.sat_run", 0, 1);
            if (i == 200) check("sat.count_200", int'(s_count), 200);
            if (i == 255) check("sat.count_255", int'(s_count), 255);
            if (i == 256) check("sat.count_256", int'(s_count), 255);
            if (i == 260) begin
                check("sat.count_260", int'(s_count), 255);
                check("sat.last_src",  int'(s_last_src), 260 % 8);
            end
        end
        check("sat.no_lockout", int'(s_lockout), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
